ones_add_serial: RTL and testbench

ONES_ADD_SERIAL -- requirements
Module: ones_add_serial

---
 rtl/ones_arith_pkg.sv | 14 +
 rtl/fulladder.sv | 16 +
 rtl/ones_add_serial.sv | 153 +++++++++++++++
 tb/tb_ones_add_serial.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ones_arith_pkg.sv
// Shared definitions for the ones'-complement arithmetic blocks:
// FSM state encoding and the default operand width.
package ones_arith_pkg;

  localparam int unsigned ONES_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    EAC  = 2'd2,
    DONE = 2'd3
  } ones_state_t;

endpackage

// File: rtl/fulladder.sv
// 1-bit full adder cell used as the per-bit datapath of the serial adders.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain sum/majority equations
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/ones_add_serial.sv
// Bit-serial ones'-complement adder. A first pass adds a and b LSB first;
// if it carries out of the MSB, a second serial pass folds that carry back
// in (end-around carry). One shared full-adder cell serves both passes.
module ones_add_serial
  import ones_arith_pkg::*;
#(
  parameter int unsigned W = ONES_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  localparam int unsigned          IDX_W    = $clog2(W);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(W - 1);

  ones_state_t       state, state_next;

  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      sum_r;
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic              carry_out_r;

  logic              fa_a;
  logic              fa_b;
  logic              fa_s;
  logic              fa_cout;
  logic              last_bit;
  logic              accept;

  assign last_bit  = (idx_r == LAST_IDX);
  assign accept    = in_valid && in_ready;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;

  // Operand mux: ADD feeds the latched operands, EAC re-feeds the partial sum
  // with a zero second operand so the carry register acts as the +1.
  always_comb begin
    fa_a = sum_r[idx_r];
    fa_b = 1'b0;
    if (state == ADD) begin
      fa_a = a_r[idx_r];
      fa_b = b_r[idx_r];
    end
  end

  fulladder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_r),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_next = fa_cout ? EAC : DONE;
        end
      end
      EAC: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial sum bits, bit index and carry register.
  // The carry register is preset to 1 at the end of ADD so it is ready as the
  // end-around carry; when EAC is skipped the value is simply never used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            idx_r   <= '0;
            carry_r <= 1'b0;
          end
        end
        ADD: begin
          sum_r[idx_r] <= fa_s;
          if (last_bit) begin
            idx_r       <= '0;
            carry_out_r <= fa_cout;
            carry_r     <= 1'b1;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            carry_r <= fa_cout;
          end
        end
        EAC: begin
          sum_r[idx_r] <= fa_s;
          // Carry out of the MSB in this pass is dropped
          carry_r      <= fa_cout;
          if (last_bit) begin
            idx_r <= '0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ones_add_serial.sv
// Directed self-checking bench for ones_add_serial (W = 4).
module tb_ones_add_serial;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks   = 0;
  int failures = 0;

  ones_add_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count edges until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Present operands for one acceptance edge, then wait for the result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0;
    wait_result(lat);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 4'b0000) begin failures++; $display("FAIL reset_sum got=%b exp=0000", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry_out got=%b exp=0", carry_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(4'b0101, 4'b0011, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 4'b1000) begin failures++; $display("FAIL basic_sum got=%b exp=1000", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL basic_carry_out got=%b exp=0", carry_out); end
    consume();
  endtask

  task automatic test_eac();
    int lat;
    run_op(4'b0111, 4'b1100, lat);
    checks++; if (lat != 8) begin failures++; $display("FAIL eac_latency got=%0d exp=8", lat); end
    checks++; if (sum !== 4'b0100) begin failures++; $display("FAIL eac_sum got=%b exp=0100", sum); end
    checks++; if (carry_out !== 1'b1) begin failures++; $display("FAIL eac_carry_out got=%b exp=1", carry_out); end
    consume();
  endtask

  task automatic test_neg_zero();
    int lat;
    run_op(4'b1111, 4'b0001, lat);
    checks++; if (lat != 8) begin failures++; $display("FAIL wrap_latency got=%0d exp=8", lat); end
    checks++; if (sum !== 4'b0001) begin failures++; $display("FAIL wrap_sum got=%b exp=0001", sum); end
    checks++; if (carry_out !== 1'b1) begin failures++; $display("FAIL wrap_carry_out got=%b exp=1", carry_out); end
    consume();
    run_op(4'b1111, 4'b0000, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL negzero_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 4'b1111) begin failures++; $display("FAIL negzero_sum got=%b exp=1111", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL negzero_carry_out got=%b exp=0", carry_out); end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    run_op(4'b0110, 4'b0001, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL hold_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cycle=%0d got=%b exp=1", i, out_valid); end
      checks++; if (sum !== 4'b0111) begin failures++; $display("FAIL hold_sum cycle=%0d got=%b exp=0111", i, sum); end
      checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL hold_carry_out cycle=%0d got=%b exp=0", i, carry_out); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cycle=%0d got=%b exp=0", i, in_ready); end
    end
    consume();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'b0011, 4'b0011, lat);
    checks++; if (sum !== 4'b0110) begin failures++; $display("FAIL b2b_first_sum got=%b exp=0110", sum); end
    // New operands offered on the very edge the result is consumed
    a = 4'b0001; b = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_early_accept got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accepted got=%b exp=0", in_ready); end
    wait_result(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 4'b0010) begin failures++; $display("FAIL b2b_second_sum got=%b exp=0010", sum); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    a = 4'b0111; b = 4'b1100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (sum !== 4'b0000) begin failures++; $display("FAIL midrst_sum got=%b exp=0000", sum); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL postrst_out_valid got=%b exp=0", out_valid); end
    run_op(4'b0010, 4'b0010, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL postrst_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 4'b0100) begin failures++; $display("FAIL postrst_sum got=%b exp=0100", sum); end
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL postrst_carry_out got=%b exp=0", carry_out); end
    consume();
  endtask

  task automatic test_operand_change();
    int lat;
    a = 4'b0111; b = 4'b1100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 8) begin failures++; $display("FAIL churn_latency got=%0d exp=8", lat); end
    checks++; if (sum !== 4'b0100) begin failures++; $display("FAIL churn_sum got=%b exp=0100", sum); end
    checks++; if (carry_out !== 1'b1) begin failures++; $display("FAIL churn_carry_out got=%b exp=1", carry_out); end
    consume();
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_eac();
    test_neg_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_operand_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
